// File: rtl/mem_arbiter_if.sv
// I/D request, memory bus and fill-return signals shared by the arbiter and its clients.
// slave = the arbiter itself, master = the requesters plus memory (as seen by a bench).
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        i_grant;
  logic        d_grant;
  logic        fill_valid;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
           fill_valid, fill_word, fill_data, i_done, d_done
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
           fill_valid, fill_word, fill_data, i_done, d_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin I/D arbiter for one memory port: 8-word line fills or single-word writes.
// Grant 1 cycle after request, fill done 13 cycles after grant; no backpressure, requests wait in IDLE.
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] S_QUIET = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              DW         = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(MEM_LAT - 1);
  localparam logic [2:0]      LAST_WORD  = 3'(LINE_WORDS - 1);

  logic [2:0]    state;
  logic [DW-1:0] drain_cnt;
  logic          last_d;     // 1 = D side was granted most recently
  logic          owner_d;
  logic          issuing;
  logic [2:0]    issue_cnt;
  logic [2:0]    ret_cnt;
  logic [11:0]   base;
  logic [15:0]   wr_addr;
  logic [15:0]   wr_data;

  logic any_req;
  logic pick_d;

  assign any_req = bus.i_req || bus.d_req;
  assign pick_d  = bus.d_req && (!bus.i_req || !last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_QUIET;
      drain_cnt <= '0;
      last_d    <= 1'b0;
      owner_d   <= 1'b0;
      issuing   <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      base      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        S_QUIET: begin
          // Reads issued before a reset may still return; wait them out.
          if (drain_cnt == DRAIN_LAST) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_IDLE: begin
          if (any_req) begin
            owner_d   <= pick_d;
            last_d    <= pick_d;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            if (pick_d && bus.d_we) begin
              state   <= S_WRITE;
              wr_addr <= bus.d_addr;
              wr_data <= bus.d_wdata;
            end else begin
              state   <= S_FILL;
              issuing <= 1'b1;
              base    <= pick_d ? bus.d_addr[15:4] : bus.i_addr[15:4];
            end
          end
        end
        S_FILL: begin
          if (issuing) begin
            if (issue_cnt == LAST_WORD) issuing <= 1'b0;
            else                        issue_cnt <= issue_cnt + 3'd1;
          end
          if (bus.mem_valid) begin
            if (ret_cnt == LAST_WORD) state <= S_DONE;
            else                      ret_cnt <= ret_cnt + 3'd1;
          end
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_QUIET;
      endcase
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge lands.
  logic run, in_fill, issue_now, writing, busy, in_done;

  assign run       = !rst;
  assign in_fill   = run && (state == S_FILL);
  assign issue_now = in_fill && issuing;
  assign writing   = run && (state == S_WRITE);
  assign in_done   = run && (state == S_DONE);
  assign busy      = in_fill || writing || in_done;

  assign bus.mem_en     = issue_now || writing;
  assign bus.mem_wr     = writing;
  assign bus.mem_addr   = issue_now ? {base, issue_cnt, 1'b0} : (writing ? wr_addr : 16'h0000);
  assign bus.mem_wdata  = writing ? wr_data : 16'h0000;

  assign bus.fill_valid = in_fill && bus.mem_valid;
  assign bus.fill_word  = bus.fill_valid ? ret_cnt : 3'd0;
  assign bus.fill_data  = bus.fill_valid ? bus.mem_rdata : 16'h0000;

  assign bus.i_grant    = busy && !owner_d;
  assign bus.d_grant    = busy && owner_d;
  assign bus.i_done     = in_done && !owner_d;
  assign bus.d_done     = in_done && owner_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model and fill/done/write scoreboards.
// Inputs change 2 time units after a rising edge; the monitor samples on the falling edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic spur = 1'b0;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LAT(4), .LINE_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: read data returns 4 cycles after the issue cycle, data = addr ^ 16'h5A5A.
  logic [3:0]  v_pipe = 4'b0000;
  logic [15:0] a_pipe [4];

  always @(posedge clk) begin
    v_pipe    <= {v_pipe[2:0], (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0)};
    a_pipe[0] <= bus.mem_addr;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
    a_pipe[3] <= a_pipe[2];
  end

  assign bus.mem_valid = v_pipe[3] | spur;
  assign bus.mem_rdata = v_pipe[3] ? (a_pipe[3] ^ 16'h5A5A) : 16'h0000;

  typedef struct packed {
    logic [2:0]  word;
    logic [15:0] data;
  } fill_t;

  fill_t       fill_q [$];
  logic [1:0]  done_q [$];   // {i_done, d_done}
  logic [31:0] write_q [$];  // {addr, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic any_out();
    return |{bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.i_grant, bus.d_grant,
             bus.fill_valid, bus.fill_word, bus.fill_data, bus.i_done, bus.d_done};
  endfunction

  // Scoreboard side: every produced fill word, done pulse and write is matched in order.
  always @(negedge clk) begin
    if (bus.fill_valid === 1'b1) begin
      if (fill_q.size() == 0) chk("fill_unexpected", 32'd1, 32'd0);
      else begin
        fill_t e;
        e = fill_q.pop_front();
        chk("fill_word", 32'(bus.fill_word), 32'(e.word));
        chk("fill_data", 32'(bus.fill_data), 32'(e.data));
      end
    end
    if ((bus.i_done === 1'b1) || (bus.d_done === 1'b1)) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'({bus.i_done, bus.d_done}), 32'd0);
      else chk("done_side", 32'({bus.i_done, bus.d_done}), 32'(done_q.pop_front()));
    end
    if (bus.mem_wr === 1'b1) begin
      if (write_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
      else chk("write_bus", {bus.mem_addr, bus.mem_wdata}, write_q.pop_front());
    end
  end

  // Called in the grant-decision cycle T; returns settled in cycle T+14.
  task automatic fill_window(input bit is_d, input logic [15:0] addr, input int drop_at);
    logic [11:0] b;
    logic [1:0]  own;
    logic [15:0] ea;
    b   = addr[15:4];
    own = is_d ? 2'b01 : 2'b10;
    for (int w = 0; w < 8; w++)
      fill_q.push_back('{word: 3'(w), data: {b, 3'(w), 1'b0} ^ 16'h5A5A});
    done_q.push_back(own);
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      if (k == drop_at) begin
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
      end
      settle();
      ea = (k <= 8) ? {b, 3'(k - 1), 1'b0} : 16'h0000;
      chk("grants",     32'({bus.i_grant, bus.d_grant}), 32'((k <= 13) ? own : 2'b00));
      chk("mem_en",     32'(bus.mem_en), 32'(k <= 8));
      chk("mem_addr",   32'(bus.mem_addr), 32'(ea));
      chk("fill_valid", 32'(bus.fill_valid), 32'((k >= 5) && (k <= 12)));
      chk("done",       32'({bus.i_done, bus.d_done}), 32'((k == 13) ? own : 2'b00));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 16'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 16'h0; bus.d_wdata = 16'h0;

    // Reset: all outputs low.
    for (int r = 0; r < 3; r++) begin
      next_cycle(); settle();
      chk("rst_outputs", 32'(any_out()), 32'd0);
    end

    // Release reset with I request already high: 4 quiet cycles, then IDLE decides.
    next_cycle();
    rst = 1'b0; bus.i_req = 1'b1; bus.i_addr = 16'h1236;
    settle();
    chk("quiet_grants", 32'({bus.i_grant, bus.d_grant}), 32'd0);
    for (int q = 1; q <= 4; q++) begin
      next_cycle(); settle();
      chk("quiet_grants", 32'({bus.i_grant, bus.d_grant}), 32'd0);
    end
    fill_window(1'b0, 16'h1236, 1);

    // I request dropped at T+3: fill still completes.
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h8A50;
    settle();
    fill_window(1'b0, 16'h8A50, 3);

    // Single-word D write.
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h00A4; bus.d_wdata = 16'hBEEF;
    write_q.push_back({16'h00A4, 16'hBEEF});
    done_q.push_back(2'b01);
    settle();
    next_cycle();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    settle();
    chk("wr_en",     32'({bus.mem_en, bus.mem_wr}), 32'b11);
    chk("wr_addr",   32'(bus.mem_addr), 32'h00A4);
    chk("wr_data",   32'(bus.mem_wdata), 32'hBEEF);
    chk("wr_grant",  32'({bus.i_grant, bus.d_grant}), 32'b01);
    chk("wr_fill",   32'(bus.fill_valid), 32'd0);
    next_cycle(); settle();
    chk("wr_done",   32'({bus.i_done, bus.d_done}), 32'b01);
    chk("wr_after",  32'({bus.mem_en, bus.mem_wr, bus.d_grant}), 32'b001);
    next_cycle(); settle();
    chk("wr_idle",   32'({bus.i_grant, bus.d_grant, bus.d_done}), 32'd0);

    // Spurious mem_valid in IDLE.
    next_cycle();
    spur = 1'b1;
    settle();
    chk("spur_fill", 32'(bus.fill_valid), 32'd0);
    chk("spur_outs", 32'(any_out()), 32'd0);
    next_cycle();
    spur = 1'b0;
    settle();
    chk("spur_after", 32'(any_out()), 32'd0);

    // Reset during an I fill at T+6; only word 0 has been returned by then.
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h4440;
    fill_q.push_back('{word: 3'd0, data: 16'h4440 ^ 16'h5A5A});
    settle();
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); settle();
      chk("abort_grant", 32'(bus.i_grant), 32'd1);
      chk("abort_addr",  32'(bus.mem_addr), 32'(16'h4440 + 16'(2 * (k - 1))));
      chk("abort_fv",    32'(bus.fill_valid), 32'(k == 5));
    end
    next_cycle();
    rst = 1'b1;
    settle();
    chk("abort_rst_outs", 32'(any_out()), 32'd0);
    for (int q = 1; q <= 5; q++) begin
      next_cycle();
      if (q == 1) rst = 1'b0;
      settle();
      chk("abort_quiet", 32'({bus.i_grant, bus.d_grant, bus.fill_valid, bus.i_done, bus.d_done}), 32'd0);
    end
    fill_window(1'b0, 16'h4440, 1);

    // Both pending after reset-state last_grant: D first, then held I, then D again.
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h2220;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h3330;
    settle();
    fill_window(1'b1, 16'h3330, 1);
    fill_window(1'b0, 16'h2220, 1);
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h5550;
    bus.d_req = 1'b1; bus.d_addr = 16'h7770;
    settle();
    fill_window(1'b1, 16'h7770, 1);
    fill_window(1'b0, 16'h5550, 1);

    next_cycle(); settle();
    chk("fill_q_empty",  32'(fill_q.size()), 32'd0);
    chk("done_q_empty",  32'(done_q.size()), 32'd0);
    chk("write_q_empty", 32'(write_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MEM_LAT, 4, cycles from a read issue to its mem_valid
- LINE_WORDS, 8, 16-bit words per cache-line fill
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge
- rst, in, 1, synchronous active-high reset
- i_req, in, 1, I-side line-fill request (level)
- i_addr, in, 16, I-side miss address
- d_req, in, 1, D-side request (level)
- d_we, in, 1, D-side 1 = single-word write, 0 = line fill
- d_addr, in, 16, D-side address
- d_wdata, in, 16, D-side write data
- mem_en, out, 1, memory access strobe
- mem_wr, out, 1, memory write strobe
- mem_addr, out, 16, memory word address
- mem_wdata, out, 16, memory write data
- mem_rdata, in, 16, memory read data
- mem_valid, in, 1, mem_rdata valid
- i_grant, out, 1, I side owns memory
- d_grant, out, 1, D side owns memory
- fill_valid, out, 1, fill word present this cycle
- fill_word, out, 3, index of the word within the line
- fill_data, out, 16, fill word data
- i_done, out, 1, one-cycle pulse: I fill complete
- d_done, out, 1, one-cycle pulse: D fill or write complete

Function
REQ-003 The FSM SHALL have five states: QUIET, IDLE, FILL, WRITE and DONE.
REQ-004 QUIET SHALL last exactly MEM_LAT cycles, counted by a drain counter; the block SHALL ignore mem_valid there and then go to IDLE.
REQ-005 The IDLE grant rule SHALL be:
- one request pending: grant it
- both pending: grant the side not granted last (last_grant register, reset value I, so D wins first)
REQ-006 Grant outcome from IDLE SHALL be:
- i_req granted, or d_req granted with d_we = 0: go to FILL, latching line base = addr[15:4]
- d_req granted with d_we = 1: go to WRITE
- last_grant SHALL update on every grant.
REQ-007 i_grant or d_grant SHALL be high from the cycle after the grant decision through DONE inclusive.
REQ-008 FILL issue: the issue counter SHALL count 0..7, with one read per cycle on the first 8 FILL cycles:
- mem_en = 1, mem_wr = 0
- mem_addr = {base, issue_cnt, 1'b0}
REQ-009 FILL return: fill_valid SHALL equal mem_valid combinationally while in FILL, with fill_data = mem_rdata and fill_word = return counter; the return counter SHALL increment on each mem_valid.
REQ-010 On the 8th mem_valid the FSM SHALL enter DONE the next cycle; DONE SHALL pulse i_done or d_done for the owner for one cycle, then return to IDLE.
REQ-011 Fill timing: grant decision at cycle T; issues at T+1..T+8; data at T+5..T+12; done at T+13; next grant decision at T+14.
REQ-012 WRITE SHALL last one cycle:
- mem_en = mem_wr = 1, mem_addr = d_addr latched at grant, mem_wdata = d_wdata latched at grant
- then DONE with d_done pulse.
REQ-013 Request deassertion after grant SHALL be ignored; the transaction SHALL always complete.
REQ-014 A request still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-015 mem_valid outside FILL SHALL be ignored, and no fill_valid SHALL be produced.
REQ-016 When not issuing, mem_en, mem_wr, mem_addr and mem_wdata SHALL be 0.
REQ-017 Counters SHALL be 3 bits and SHALL NOT wrap within a transaction.

Reset
REQ-018 rst SHALL take effect at a clock edge.
REQ-019 On reset the FSM SHALL enter QUIET with the drain counter at 0, last_grant = I, and all counters at 0.
REQ-020 During reset all outputs SHALL be 0.
REQ-021 Reset mid-FILL or mid-WRITE SHALL abort the transaction with no done pulse; stale returns SHALL be absorbed by QUIET.

Verification
REQ-022 Reset then i_req = 1, i_addr = 16'h1236 at T:
- i_grant from T+1
- mem_addr 16'h1230..16'h123E at T+1..T+8
- fill_word 0..7 at T+5..T+12
- i_done at T+13
REQ-023 i_req and d_req both high (d_we = 0) from reset: D fill first, then I fill starting at T+14; a second simultaneous pair grants D again, because last_grant alternates.
REQ-024 d_req = 1, d_we = 1, d_addr = 16'h00A4, d_wdata = 16'hBEEF: one cycle with mem_en = mem_wr = 1, addr 16'h00A4, data 16'hBEEF, then d_done; no fill_valid.
REQ-025 rst asserted at T+6 of an I fill, memory model still returns 4 words: no fill_valid and no i_done; grants blocked for 4 cycles after rst falls; the next fill produces correct indices 0..7.
REQ-026 i_req dropped at T+3: the fill still completes with 8 fill_valid and i_done at T+13.
REQ-027 Spurious mem_valid while IDLE: no fill_valid, and no state change.
